// File: rtl/riscv_pkg.sv
// riscv_pkg: shared M-extension encodings and the multiply/divide FSM states.
package riscv_pkg;
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;
    typedef enum logic [1:0] {MD_IDLE, MD_BUSY, MD_DONE} muldiv_state_e;
endpackage

// File: rtl/muldiv_iter_core.sv
// muldiv_iter_core: unsigned radix-2 datapath, shift-add multiply or restoring divide.
// {hi,lo} ends as the 2*XLEN product, or as {remainder, quotient}.
module muldiv_iter_core #(
    parameter int XLEN = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   load_i,
    input  logic                   step_i,
    input  logic                   clear_i,
    input  logic                   div_i,
    input  logic [XLEN-1:0]        a_i,
    input  logic [XLEN-1:0]        b_i,
    output logic [XLEN-1:0]        hi_d_o,
    output logic [XLEN-1:0]        lo_d_o,
    output logic [$clog2(XLEN):0]  cnt_o
);
    localparam int CW = $clog2(XLEN) + 1;
    logic [XLEN-1:0] hi_q, lo_q, b_q;
    logic            div_q;
    logic [CW-1:0]   cnt_q;
    logic [XLEN:0]   sum, shl, diff;
    // The trial subtraction borrows into bit XLEN whenever the shifted remainder is below the divisor.
    always_comb begin
        sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shl    = {hi_q, lo_q[XLEN-1]};
        diff   = shl - {1'b0, b_q};
        hi_d_o = div_q ? (diff[XLEN] ? shl[XLEN-1:0] : diff[XLEN-1:0]) : sum[XLEN:1];
        lo_d_o = div_q ? {lo_q[XLEN-2:0], ~diff[XLEN]} : {sum[0], lo_q[XLEN-1:1]};
    end
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            hi_q  <= '0;
            lo_q  <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
            cnt_q <= '0;
        end else if (load_i) begin
            hi_q  <= '0;
            lo_q  <= a_i;
            b_q   <= b_i;
            div_q <= div_i;
            cnt_q <= CW'(XLEN);
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (step_i) begin
            hi_q  <= hi_d_o;
            lo_q  <= lo_d_o;
            cnt_q <= cnt_q - 1'b1;
        end
    end
    assign cnt_o = cnt_q;
endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: execute-stage RV32M unit; owns the FSM, operand signs, special cases
// and the result register around the unsigned iterative core.
module ex_muldiv
    import riscv_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_startE,
    input  logic            i_kill,
    input  logic [2:0]      i_funct3E,
    input  logic [XLEN-1:0] i_rs1_dataE,
    input  logic [XLEN-1:0] i_rs2_dataE,
    output logic            o_stallE,
    output logic            o_done,
    output logic [XLEN-1:0] o_result
);
    localparam int CW = $clog2(XLEN) + 1;
    muldiv_state_e     state_q, state_d;
    logic [2:0]        op_q;
    logic              qneg_q, rneg_q;
    logic [XLEN-1:0]   res_q, res_d;
    logic              load, step, clear;
    logic [XLEN-1:0]   hi_d, lo_d;
    logic [CW-1:0]     cnt;
    logic              is_div, is_rem, sgn_a, sgn_b, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0]   a_mag, b_mag, spec_res, quo, rmd, fin;
    logic [2*XLEN-1:0] prod;
    always_comb begin
        is_div   = i_funct3E inside {F3_DIV, F3_DIVU, F3_REM, F3_REMU};
        is_rem   = i_funct3E inside {F3_REM, F3_REMU};
        sgn_a    = i_funct3E inside {F3_MULH, F3_MULHSU, F3_DIV, F3_REM};
        sgn_b    = i_funct3E inside {F3_MULH, F3_DIV, F3_REM};
        a_neg    = sgn_a & i_rs1_dataE[XLEN-1];
        b_neg    = sgn_b & i_rs2_dataE[XLEN-1];
        a_mag    = a_neg ? -i_rs1_dataE : i_rs1_dataE;
        b_mag    = b_neg ? -i_rs2_dataE : i_rs2_dataE;
        div_zero = is_div & (i_rs2_dataE == '0);
        div_ovf  = (i_funct3E inside {F3_DIV, F3_REM}) & (i_rs1_dataE == {1'b1, {(XLEN-1){1'b0}}})
                 & (i_rs2_dataE == '1);
        spec_res = div_zero ? (is_rem ? i_rs1_dataE : '1) : (is_rem ? '0 : i_rs1_dataE);
    end
    // Sign fix-up works on the core's next-state values so it lands on the final-step edge.
    always_comb begin
        prod = qneg_q ? -{hi_d, lo_d} : {hi_d, lo_d};
        quo  = qneg_q ? -lo_d : lo_d;
        rmd  = rneg_q ? -hi_d : hi_d;
        fin  = (op_q inside {F3_REM, F3_REMU}) ? rmd :
               (op_q inside {F3_DIV, F3_DIVU}) ? quo :
               (op_q inside {F3_MULH, F3_MULHSU, F3_MULHU}) ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
    end
    always_comb begin
        state_d = state_q;
        res_d   = res_q;
        load    = 1'b0;
        step    = 1'b0;
        clear   = 1'b0;
        case (state_q)
            MD_IDLE: if (i_startE && !i_kill) begin
                state_d = (div_zero || div_ovf) ? MD_DONE : MD_BUSY;
                res_d   = (div_zero || div_ovf) ? spec_res : res_q;
                load    = !(div_zero || div_ovf);
            end
            MD_BUSY: begin
                clear   = i_kill;
                step    = !i_kill;
                state_d = i_kill ? MD_IDLE : (cnt == CW'(1)) ? MD_DONE : MD_BUSY;
                res_d   = (!i_kill && cnt == CW'(1)) ? fin : res_q;
            end
            default: state_d = MD_IDLE;
        endcase
    end
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= MD_IDLE;
            res_q   <= '0;
            op_q    <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            res_q   <= res_d;
            if (load) begin
                op_q   <= i_funct3E;
                qneg_q <= a_neg ^ b_neg;
                rneg_q <= a_neg;
            end
        end
    end
    muldiv_iter_core #(.XLEN(XLEN)) u_core (
        .clk_i   (i_clk),
        .rst_i   (i_rst),
        .load_i  (load),
        .step_i  (step),
        .clear_i (clear),
        .div_i   (is_div),
        .a_i     (a_mag),
        .b_i     (b_mag),
        .hi_d_o  (hi_d),
        .lo_d_o  (lo_d),
        .cnt_o   (cnt)
    );
    assign o_stallE = !i_kill & (((state_q == MD_IDLE) & i_startE) | (state_q == MD_BUSY));
    assign o_done   = (state_q == MD_DONE);
    assign o_result = res_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: scoreboard bench for ex_muldiv; expected results queued at issue, popped on o_done.
module tb_ex_muldiv;
    import riscv_pkg::*;
    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;
    logic        clk = 1'b0;
    logic        rst, start, kill, stall, done;
    logic [2:0]  f3;
    logic [31:0] rs1, rs2, result;
    exp_t        sb[$];
    int          checks = 0;
    int          passes = 0;
    always #5 clk = ~clk;
    ex_muldiv #(.XLEN(32)) dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_startE    (start),
        .i_kill      (kill),
        .i_funct3E   (f3),
        .i_rs1_dataE (rs1),
        .i_rs2_dataE (rs2),
        .o_stallE    (stall),
        .o_done      (done),
        .o_result    (result)
    );
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else passes++;
    endtask
    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = (f == F3_MULH)   ? 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b})) :
            (f == F3_MULHSU) ? 64'($signed({{32{a[31]}}, a}) * $signed({32'b0, b})) :
                               {32'b0, a} * {32'b0, b};
        if (f == F3_MUL) return p[31:0];
        if (f inside {F3_MULH, F3_MULHSU, F3_MULHU}) return p[63:32];
        if (b == 0) return (f inside {F3_REM, F3_REMU}) ? a : 32'hFFFF_FFFF;
        if (f inside {F3_DIV, F3_REM} && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return (f == F3_DIV) ? a : 32'h0;
        case (f)
            F3_DIV:  return 32'($signed(a) / $signed(b));
            F3_REM:  return 32'($signed(a) % $signed(b));
            F3_DIVU: return a / b;
            default: return a % b;
        endcase
    endfunction
    always @(negedge clk) if (done) begin
        if (sb.size() == 0) chk("spurious_done", 64'(done), 64'(0));
        else begin
            exp_t e;
            e = sb.pop_front();
            chk(e.tag, 64'(result), 64'(e.val));
        end
    end
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp, input int exp_st, input string tag);
        int st;
        bit got;
        st  = 0;
        got = 1'b0;
        @(negedge clk);
        sb.push_back('{tag, exp});
        start = 1'b1;
        f3    = f;
        rs1   = a;
        rs2   = b;
        for (int n = 0; n < 100; n++) begin
            #1;
            if (done) begin
                got = 1'b1;
                break;
            end
            st += int'(stall);
            @(negedge clk);
            if (n == 0) begin
                rs1 = $urandom;
                rs2 = $urandom;
            end
        end
        start = 1'b0;
        chk({tag, "_done"}, 64'(got), 64'(1));
        chk({tag, "_stalls"}, 64'(st), 64'(exp_st));
        if (!got && sb.size() != 0) void'(sb.pop_back());
    endtask
    initial begin
        int ndone;
        rst   = 1'b1;
        start = 1'b0;
        kill  = 1'b0;
        f3    = '0;
        rs1   = '0;
        rs2   = '0;
        repeat (2) @(negedge clk);
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_result", 64'(result), 64'(0));
        chk("rst_stall", 64'(stall), 64'(0));
        rst = 1'b0;
        run_op(F3_MUL,    32'h7,         32'hFFFF_FFFD, 32'hFFFF_FFEB, 33, "mul_7x-3");
        run_op(F3_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33, "mulh_min");
        run_op(F3_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33, "mulhu_max");
        run_op(F3_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, "mulhsu_max");
        run_op(F3_DIV,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 33, "div_-7/2");
        run_op(F3_REM,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 33, "rem_-7/2");
        run_op(F3_DIVU,   32'd100,       32'd7,         32'd14,        33, "divu_100/7");
        run_op(F3_REMU,   32'd100,       32'd7,         32'd2,         33, "remu_100/7");
        run_op(F3_DIV,    32'd1234,      32'h0,         32'hFFFF_FFFF, 1,  "div_by0");
        run_op(F3_REMU,   32'd5,         32'h0,         32'd5,         1,  "remu_by0");
        run_op(F3_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  "div_ovf");
        run_op(F3_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1,  "rem_ovf");
        for (int i = 0; i < 8; i++) begin
            logic [2:0]  rf;
            logic [31:0] ra, rb;
            rf = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 1000)) ^ {32{ra[31]}};
            run_op(rf, ra, rb, model(rf, ra, rb), 33, $sformatf("rand%0d_f%0d", i, rf));
        end
        @(negedge clk);
        start = 1'b1;
        f3    = F3_DIV;
        rs1   = 32'd1000;
        rs2   = 32'd7;
        repeat (10) @(posedge clk);
        #2 kill = 1'b1;
        #1 chk("kill_stall", 64'(stall), 64'(0));
        @(posedge clk);
        #2 kill = 1'b0;
        start = 1'b0;
        #1 chk("kill_idle", 64'(dut.state_q), 64'(MD_IDLE));
        chk("kill_done", 64'(done), 64'(0));
        ndone = 0;
        repeat (40) @(negedge clk) ndone += int'(done);
        chk("kill_no_done", 64'(ndone), 64'(0));
        run_op(F3_DIVU, 32'd9, 32'd3, 32'd3, 33, "divu_after_kill");
        @(negedge clk);
        start = 1'b1;
        f3    = F3_MUL;
        rs1   = 32'h1234;
        rs2   = 32'h5678;
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        start = 1'b0;
        #1 chk("arst_state", 64'(dut.state_q), 64'(MD_IDLE));
        chk("arst_result", 64'(result), 64'(0));
        chk("arst_done", 64'(done), 64'(0));
        @(negedge clk) rst = 1'b0;
        run_op(F3_MUL, 32'd3, 32'd4, 32'd12, 33, "b2b_3x4");
        run_op(F3_MUL, 32'd5, 32'd6, 32'd30, 33, "b2b_5x6");
        repeat (3) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'(0));
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
